comparador_serial_izqder: RTL
=============================

COMPARADOR_SERIAL_IZQDER -- requirements
Module: comparador_serial_izqder

Interface
REQ-001 The block SHALL have parameter NUM_DIG, default 4: number of digits per operand.
REQ-002 The block SHALL have parameter DIG_W, default 3: width of one digit in bits.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1) is the rising-edge clock, and rst (input, 1) is the synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: begins a comparison.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a_dig and b_dig hold a valid digit pair.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a digit pair this cycle.
REQ-007 The block SHALL have port a_dig, input, DIG_W bits: digit of A, MSB-first order.
REQ-008 The block SHALL have port b_dig, input, DIG_W bits: digit of B, MSB-first order.
REQ-009 The block SHALL have port busy, output, 1 bit: a comparison is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a final result.
REQ-011 The block SHALL have ports mayor, menor and igual, output, 1 bit each: held result flags for A>B, A<B and A=B.

Function
REQ-012 The FSM SHALL have three states: IDLE, RECV and FIN.
REQ-013 In IDLE with start=1, the block SHALL enter RECV and clear the digit counter and the carry state.
REQ-014 On the same IDLE+start edge, the block SHALL clear mayor, menor and igual.
REQ-015 In IDLE, in_valid SHALL be ignored.
REQ-016 in_ready SHALL be 1 exactly in RECV.
REQ-017 busy SHALL be 1 in RECV and FIN.
REQ-018 A digit pair SHALL be accepted on an edge where in_valid=1 and in_ready=1; in_valid=0 in RECV stalls with no state change.
REQ-019 The carry state (f,g) SHALL encode: 00 = equal so far, 10 = A greater, 01 = A less; 11 SHALL be unreachable.
REQ-020 On accept with carry 00, the next carry SHALL be 10 if a_dig>b_dig, 01 if a_dig<b_dig, and 00 otherwise, using unsigned compare.
REQ-021 On accept with carry 10 or 01, the carry SHALL hold (left-to-right early decision); later digits SHALL still be consumed.
REQ-022 The digit counter SHALL increment on each accept.
REQ-023 When the accepted digit is number NUM_DIG, the FSM SHALL go RECV->FIN.
REQ-024 In FIN, for exactly one cycle: done=1, and mayor/menor/igual SHALL be loaded from the final carry (10->mayor, 01->menor, 00->igual).
REQ-025 The FSM SHALL go FIN->IDLE unconditionally.
REQ-026 Latency: if the last digit is accepted at edge k, done=1 and the flags SHALL be valid in the cycle after edge k.
REQ-027 Result flags SHALL hold in IDLE until the next accepted start or reset.
REQ-028 Exactly one flag SHALL be 1 while a result is held.
REQ-029 start in RECV or FIN SHALL be ignored.
REQ-030 The counter SHALL be $clog2(NUM_DIG+1) bits wide and SHALL never wrap within an operation.

Reset
REQ-031 With rst=1 at an edge, the block SHALL go to IDLE, regardless of state, including mid-RECV.
REQ-032 With rst=1 at an edge, the counter SHALL be 0 and the carry SHALL be 00.
REQ-033 With rst=1 at an edge, in_ready, busy, done, mayor, menor and igual SHALL all be 0.
REQ-034 rst SHALL take priority over start and in_valid in the same cycle.
REQ-035 After rst, all flags SHALL be 0; this is the only state where all flags are 0 outside an operation.

Structure
REQ-036 A shared package file SHALL hold: FSM state encodings (IDLE, RECV, FIN), carry encodings (EQ=2'b00, GT=2'b10, LT=2'b01), and the NUM_DIG/DIG_W defaults.
REQ-037 The per-digit next-carry logic SHALL be one combinational sub-module, celda_izqder (inputs f_in, g_in, a_dig, b_dig; outputs f_out, g_out), instantiated once and reused every cycle.
REQ-038 All state SHALL reside in comparador_serial_izqder.

Verification (NUM_DIG=4, DIG_W=3)
REQ-039 Equal operands: start; A=0,0,0,0 and B=0,0,0,0 with in_valid continuous -> done one cycle after the 4th accept, with igual=1, mayor=0, menor=0.
REQ-040 Late greater: A=3,5,1,0 and B=3,4,7,7 -> mayor=1 after the 4th digit; later digits SHALL not flip the result.
REQ-041 Early less: A=1,7,7,7 and B=6,0,0,0 -> menor=1 while carry stays 01 from the 1st digit on; flags held in IDLE afterward.
REQ-042 Stall: in_valid low for 3 cycles between digits 2 and 3 -> no counter change during the gap; result identical to the unstalled run; done occurs exactly 1 cycle after the last accept.
REQ-043 Reset mid-operation: rst pulse after 2 accepts -> IDLE with in_ready=0, busy=0 and all flags 0; a new start+4 digits then compares correctly.
REQ-044 Ignored start: start=1 asserted during RECV after 1 accept -> counter not cleared; the result reflects all 4 digits of the original operation.

Source files
------------

// File: rtl/comparador_serial_izqder_pkg.sv
// Shared encodings for the serial MSB-first digit comparator: FSM states,
// carry (f,g) codes and default operand geometry.
package comparador_serial_izqder_pkg;

  localparam int NUM_DIG_DEF = 4;
  localparam int DIG_W_DEF   = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Carry is {f,g}; 2'b11 never occurs.
  localparam logic [1:0] CARRY_EQ = 2'b00;
  localparam logic [1:0] CARRY_GT = 2'b10;
  localparam logic [1:0] CARRY_LT = 2'b01;

endpackage

// File: rtl/comparador_serial_izqder_celda.sv
// Next-carry cell, purely combinational (0 cycles); no handshake.
// Once a decision has been made the carry sticks, since a more significant digit wins.
module celda_izqder
  import comparador_serial_izqder_pkg::*;
#(
  parameter int DIG_W = DIG_W_DEF
) (
  input  logic             f_in,
  input  logic             g_in,
  input  logic [DIG_W-1:0] a_dig,
  input  logic [DIG_W-1:0] b_dig,
  output logic             f_out,
  output logic             g_out
);

  always_comb begin
    f_out = f_in;
    g_out = g_in;
    if ({f_in, g_in} == CARRY_EQ) begin
      f_out = (a_dig > b_dig);
      g_out = (a_dig < b_dig);
    end
  end

endmodule

// File: rtl/comparador_serial_izqder.sv
// Serial MSB-first comparator of two NUM_DIG-digit operands; done and the flags
// appear one cycle after the last accept. in_valid/in_ready handshake, where in_valid=0 stalls.
module comparador_serial_izqder
  import comparador_serial_izqder_pkg::*;
#(
  parameter int NUM_DIG = NUM_DIG_DEF,
  parameter int DIG_W   = DIG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIG_W-1:0] a_dig,
  input  logic [DIG_W-1:0] b_dig,
  output logic             busy,
  output logic             done,
  output logic             mayor,
  output logic             menor,
  output logic             igual
);

  localparam int CNT_W = $clog2(NUM_DIG + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIG - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             f, g;
  logic             f_nxt, g_nxt;

  celda_izqder #(.DIG_W(DIG_W)) u_celda (
    .f_in  (f),
    .g_in  (g),
    .a_dig (a_dig),
    .b_dig (b_dig),
    .f_out (f_nxt),
    .g_out (g_nxt)
  );

  assign in_ready = (state == ST_RECV);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      f     <= 1'b0;
      g     <= 1'b0;
      mayor <= 1'b0;
      menor <= 1'b0;
      igual <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_RECV;
            cnt    <= '0;
            {f, g} <= CARRY_EQ;
            mayor  <= 1'b0;
            menor  <= 1'b0;
            igual  <= 1'b0;
          end
        end
        ST_RECV: begin
          if (in_valid) begin
            cnt    <= cnt + 1'b1;
            f      <= f_nxt;
            g      <= g_nxt;
            // Flags are loaded on the last accept so they are valid during FIN.
            if (cnt == LAST_IDX) begin
              state <= ST_FIN;
              mayor <= ({f_nxt, g_nxt} == CARRY_GT);
              menor <= ({f_nxt, g_nxt} == CARRY_LT);
              igual <= ({f_nxt, g_nxt} == CARRY_EQ);
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
